// File: rtl/arm_dp_sequencer.sv
// Control sequencer for the ARM data-processing ALU: IDLE -> DECODE -> EXEC -> WB, owns CPSR NZCV.
// Optional macro ARM_DP_COND_EXEC_EN enables condition-field evaluation (otherwise everything runs as AL).
module arm_dp_sequencer #(
  parameter int          NUM_REGS   = 16,
  parameter logic [3:0]  CPSR_RESET = 4'h0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [31:0]                 instr,
  output logic [4:0]                  alu_op,
  output logic                        alu_s,
  output logic                        alu_out_en,
  output logic [3:0]                  alu_flags_cpsr,
  input  logic [3:0]                  alu_flags_in,
  output logic [$clog2(NUM_REGS)-1:0] rn_sel,
  output logic [$clog2(NUM_REGS)-1:0] rd_sel,
  output logic                        imm_sel,
  output logic                        rf_we,
  output logic                        done,
  output logic                        skipped,
  output logic                        illegal
);

  localparam int RW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  cpsr_q, cpsr_d;
  logic        exec_q, exec_d;
  logic        hold_q, hold_d;
  logic        skip_q, skip_d;
  logic        ill_q, ill_d;

  logic [3:0]  opc;
  logic        dp_ok;
  logic        cond_pass;
  logic        is_cmp;
  logic        s_eff;
  logic        act;
  logic        unused_bits;

  assign opc    = instr_q[24:21];
  assign dp_ok  = (instr_q[27:26] == 2'b00);
  assign is_cmp = (opc[3:2] == 2'b10);
  assign s_eff  = instr_q[20] | is_cmp;

  assign unused_bits = ^{instr_q[31:28], instr_q[11:0]};

`ifdef ARM_DP_COND_EXEC_EN
  always_comb begin
    cond_pass = 1'b0;
    case (instr_q[31:28])
      4'h0: cond_pass = cpsr_q[2];
      4'h1: cond_pass = !cpsr_q[2];
      4'h2: cond_pass = cpsr_q[1];
      4'h3: cond_pass = !cpsr_q[1];
      4'h4: cond_pass = cpsr_q[3];
      4'h5: cond_pass = !cpsr_q[3];
      4'h6: cond_pass = cpsr_q[0];
      4'h7: cond_pass = !cpsr_q[0];
      4'h8: cond_pass = cpsr_q[1] & !cpsr_q[2];
      4'h9: cond_pass = !cpsr_q[1] | cpsr_q[2];
      4'hA: cond_pass = (cpsr_q[3] == cpsr_q[0]);
      4'hB: cond_pass = (cpsr_q[3] != cpsr_q[0]);
      4'hC: cond_pass = !cpsr_q[2] & (cpsr_q[3] == cpsr_q[0]);
      4'hD: cond_pass = cpsr_q[2] | (cpsr_q[3] != cpsr_q[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  assign cond_pass = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cpsr_d  = cpsr_q;
    exec_d  = exec_q;
    hold_d  = hold_q;
    skip_d  = skip_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          exec_d  = 1'b0;
          hold_d  = 1'b0;
          skip_d  = 1'b0;
          ill_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Non-executing instructions idle one extra DECODE cycle so every retire lands at the same cycle.
        if (!dp_ok || !cond_pass) begin
          if (hold_q) begin
            hold_d  = 1'b0;
            ill_d   = !dp_ok;
            skip_d  = dp_ok & !cond_pass;
            state_d = S_WB;
          end else begin
            hold_d  = 1'b1;
          end
        end else begin
          exec_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (exec_q && s_eff) cpsr_d = alu_flags_in;
        exec_d  = 1'b0;
        skip_d  = 1'b0;
        ill_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cpsr_q  <= CPSR_RESET;
      exec_q  <= 1'b0;
      hold_q  <= 1'b0;
      skip_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cpsr_q  <= cpsr_d;
      exec_q  <= exec_d;
      hold_q  <= hold_d;
      skip_q  <= skip_d;
      ill_q   <= ill_d;
    end
  end

  // ALU-facing controls are live only while an executing instruction occupies EXEC or WB.
  assign act            = (state_q == S_EXEC) | ((state_q == S_WB) & exec_q);
  assign instr_ready    = (state_q == S_IDLE);
  assign alu_out_en     = act;
  assign alu_op         = !act ? 5'b00000 : ((opc == 4'hD) ? 5'b10000 : {1'b0, opc});
  assign alu_s          = act & s_eff;
  assign rn_sel         = act ? instr_q[16 +: RW] : '0;
  assign rd_sel         = act ? instr_q[12 +: RW] : '0;
  assign imm_sel        = act & instr_q[25];
  assign rf_we          = (state_q == S_WB) & exec_q & !is_cmp;
  assign done           = (state_q == S_WB);
  assign skipped        = done & skip_q;
  assign illegal        = done & ill_q;
  assign alu_flags_cpsr = cpsr_q;

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Randomized scoreboard bench for arm_dp_sequencer: driver pushes spec-derived expectations, monitor checks retires.
module tb_arm_dp_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  alu_op;
  logic        alu_s, alu_out_en;
  logic [3:0]  alu_flags_cpsr;
  logic [3:0]  alu_flags_in = '0;
  logic [3:0]  rn_sel, rd_sel;
  logic        imm_sel, rf_we, done, skipped, illegal;

  arm_dp_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_s(alu_s), .alu_out_en(alu_out_en),
    .alu_flags_cpsr(alu_flags_cpsr), .alu_flags_in(alu_flags_in), .rn_sel(rn_sel),
    .rd_sel(rd_sel), .imm_sel(imm_sel), .rf_we(rf_we), .done(done), .skipped(skipped),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         exec, skip, ill, we, s;
    logic [4:0] op;
    logic [3:0] rn, rd;
    bit         imm;
    logic [3:0] cpsr_after;
    int         t_acc;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] mcpsr = 4'h0;
  bit         mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef ARM_DP_COND_EXEC_EN
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cf;         4'h3: return !cf;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cf && !z;   4'h9: return !cf || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == c) && (f == f);
`endif
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] cp);
    exp_t e;
    logic [3:0] opc;
    bit test_only;
    opc = ins[24:21];
    test_only = (opc >= 4'h8) && (opc <= 4'hB);
    e.ill  = (ins[27:26] != 2'b00);
    e.skip = !e.ill && !cond_ok(ins[31:28], cp);
    e.exec = !e.ill && !e.skip;
    e.op   = (opc == 4'hD) ? 5'd16 : 5'(opc);
    e.s    = ins[20] || test_only;
    e.we   = e.exec && !test_only;
    e.rn   = ins[19:16];
    e.rd   = ins[15:12];
    e.imm  = ins[25];
    e.cpsr_after = (e.exec && e.s) ? fl : cp;
    e.t_acc = 0;
    return e;
  endfunction

  // Driver: offer instruction, present its flags once the previous one has retired, record expectation at accept.
  task automatic issue(input logic [31:0] ins, input logic [3:0] fl, input int gap, input bit push);
    int   w;
    exp_t e;
    if (gap > 0) begin
      instr_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    instr = ins;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!instr_ready) begin
      n_err++;
      $display("FAIL accept_timeout: instr_ready stayed 0, expected 1 within 20 cycles");
      return;
    end
    alu_flags_in = fl;
    if (push) begin
      e = model(ins, fl, mcpsr);
      e.t_acc = cyc + 1;
      mcpsr = e.cpsr_after;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  bit         seen_en = 0, seen_s = 0, cpsr_pend = 0;
  logic [3:0] pend_cpsr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      seen_en = 0; seen_s = 0; cpsr_pend = 0;
    end else begin
      if (cpsr_pend) begin
        chk("cpsr_next_idle", alu_flags_cpsr, pend_cpsr);
        cpsr_pend = 0;
      end
      seen_en |= alu_out_en;
      seen_s  |= alu_s;
      if (done) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_done: done=1 with no instruction outstanding");
        end else begin
          e = sbq.pop_front();
          chk("retire_latency", cyc - e.t_acc, 2);
          chk("skipped", skipped, e.skip);
          chk("illegal", illegal, e.ill);
          chk("rf_we", rf_we, e.we);
          chk("alu_out_en_seen", seen_en, e.exec);
          chk("alu_s_seen", seen_s, e.exec && e.s);
          if (e.exec) begin
            chk("alu_op", alu_op, e.op);
            chk("rn_sel", rn_sel, e.rn);
            chk("rd_sel", rd_sel, e.rd);
            chk("imm_sel", imm_sel, e.imm);
          end
          pend_cpsr = e.cpsr_after;
          cpsr_pend = 1;
        end
        seen_en = 0; seen_s = 0;
      end
    end
  end

  task automatic drain();
    int k = 0;
    instr_valid = 1'b0;
    while (sbq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d retires outstanding, expected 0", sbq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] dir_ins [8] = '{32'hE0810002, 32'hE0910002, 32'hE1510002, 32'hE1510002,
                               32'h01A00001, 32'hE1510002, 32'h01A00001, 32'h0C000000};
  logic [3:0]  dir_fl  [8] = '{4'b1011, 4'b0110, 4'b0100, 4'b0000,
                               4'b1111, 4'b0100, 4'b0000, 4'b1111};

  initial begin
    logic [31:0] r;
    #12;
    @(negedge clk);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_cpsr", alu_flags_cpsr, 4'h0);
    chk("rst_outputs", {alu_op, alu_s, alu_out_en, rn_sel, rd_sel, imm_sel, rf_we, done, skipped, illegal}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) issue(dir_ins[i], dir_fl[i], (i == 7) ? 0 : 1, 1'b1);
    // Back-to-back with instr_valid held high while the sequencer is busy.
    for (int i = 0; i < 4; i++) issue(32'hE0B54003 + 32'(i), 4'(i * 5), 0, 1'b1);
    drain();

    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      if ($urandom_range(7) != 0) r[27:26] = 2'b00;
      issue(r, 4'($urandom), $urandom_range(2), 1'b1);
    end
    drain();

    // Reset asserted while an ADDS is in EXEC.
    mon_en = 1'b0;
    issue(32'hE0910002, 4'b1111, 1, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("abort_instr_ready", instr_ready, 1);
    chk("abort_rf_we", rf_we, 0);
    chk("abort_alu_out_en", alu_out_en, 0);
    chk("abort_done", done, 0);
    chk("abort_cpsr", alu_flags_cpsr, 4'h0);
    @(negedge clk);
    chk("abort_cpsr_held", alu_flags_cpsr, 4'h0);
    reset_n = 1'b1;
    mcpsr = 4'h0;
    @(negedge clk);
    mon_en = 1'b1;
    issue(32'hE0B10002, 4'b0010, 1, 1'b1);
    issue(32'hE0A10002, 4'b1001, 0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
